// File: rtl/lms_filter_mc.sv
// ---------------------------------------------------------------------------
// lms_filter_mc
//
// Multi-channel adaptive FIR filter using the LMS algorithm. Each channel
// owns its own delay line and weight set. A single shared multiplier is
// time-multiplexed: one product per cycle while filtering (MAC), then one
// weight update per cycle while adapting (UPDATE).
//
// Per-sample timing (sample accepted at rising edge T):
//   T+1 .. T+FILTER_ORDER      : MAC, one w[k]*x[k] per edge
//   T+FILTER_ORDER+1           : ERR, y/err registered, out_valid pulses
//   T+FILTER_ORDER+2 .. +2F+1  : UPDATE (only when adapt_en was latched high)
//
// Parameters:
//   DATA_WIDTH   - signed width of samples, weights and results
//   FILTER_ORDER - taps per channel (>= 2)
//   MU_BITS      - step size mu = 2^-MU_BITS (arithmetic right shift)
//   N_CH         - number of independent channels
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   reset      - asynchronous, active-low reset
//   in_valid   - sample valid
//   in_ready   - high only while idle (low during reset)
//   ch_in      - channel of the offered sample (>= N_CH is dropped)
//   x_in       - filter input sample
//   d_in       - desired response
//   adapt_en   - enables the weight update for this sample
//   out_valid  - one-cycle result strobe
//   ch_out     - channel of the result
//   y_out      - saturated filter output
//   err_out    - saturated error d - y
//
// Build option:
//   LMS_MC_SIGN_ERROR_EN - when defined, uses sign-error LMS
//                          (w += (sgn(err)*x) >>> MU_BITS); interface and
//                          timing are identical in both builds.
// ---------------------------------------------------------------------------
module lms_filter_mc #(
    parameter int DATA_WIDTH   = 32,
    parameter int FILTER_ORDER = 5,
    parameter int MU_BITS      = 11,
    parameter int N_CH         = 2,
    localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CH_W-1:0]              ch_in,
    input  logic signed [DATA_WIDTH-1:0] x_in,
    input  logic signed [DATA_WIDTH-1:0] d_in,
    input  logic                         adapt_en,
    output logic                         out_valid,
    output logic [CH_W-1:0]              ch_out,
    output logic signed [DATA_WIDTH-1:0] y_out,
    output logic signed [DATA_WIDTH-1:0] err_out
);

    localparam int DW    = DATA_WIDTH;
    localparam int K_W   = $clog2(FILTER_ORDER);
    localparam int PW    = 2 * DW;
    localparam int ACC_W = PW + K_W;

    localparam logic [K_W-1:0] TAP_LAST = K_W'(FILTER_ORDER - 1);

    // Signed DATA_WIDTH limits, sign-extended to the widest internal width
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_ERR,
        S_UPDATE
    } state_t;

    state_t                  state_q;
    logic [K_W-1:0]          tap_q;
    logic [CH_W-1:0]         ch_q;
    logic signed [DW-1:0]    d_q;
    logic                    adapt_q;
    logic signed [ACC_W-1:0] acc_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [CH_W-1:0]         ch_out_q;
    logic signed [DW-1:0]    y_q;
    logic signed [DW-1:0]    err_q;

    logic signed [DW-1:0] xLine_q  [N_CH][FILTER_ORDER];
    logic signed [DW-1:0] weight_q [N_CH][FILTER_ORDER];

    logic                    chValid;
    logic signed [DW-1:0]    xTap;
    logic signed [DW-1:0]    wTap;
    logic signed [PW-1:0]    prod_d;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [DW-1:0]    y_d;
    logic signed [DW:0]      errWide;
    logic signed [DW-1:0]    err_d;
    logic signed [PW-1:0]    stepProd;
    logic signed [PW-1:0]    delta;
    logic signed [DW-1:0]    weight_d;

    // Clamp any internal value into the signed DATA_WIDTH range
    function automatic logic signed [DW-1:0] satToData(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[DW-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[DW-1:0];
        end
        return v[DW-1:0];
    endfunction

    assign chValid = (32'(ch_in) < N_CH);

    // Shared datapath: the current tap feeds both the MAC product and the
    // weight update. err_q is the registered (saturated) error, so the
    // update uses exactly the value reported on err_out.
    always_comb begin
        xTap    = xLine_q[ch_q][tap_q];
        wTap    = weight_q[ch_q][tap_q];
        prod_d  = PW'(wTap) * PW'(xTap);
        acc_d   = acc_q + ACC_W'(prod_d);
        y_d     = satToData(acc_q);
        errWide = (DW+1)'(d_q) - (DW+1)'(y_d);
        err_d   = satToData(ACC_W'(errWide));
`ifdef LMS_MC_SIGN_ERROR_EN
        if (err_q[DW-1]) begin
            stepProd = -PW'(xTap);
        end else if (err_q != '0) begin
            stepProd = PW'(xTap);
        end else begin
            stepProd = '0;
        end
`else
        stepProd = PW'(err_q) * PW'(xTap);
`endif
        delta    = stepProd >>> MU_BITS;
        weight_d = satToData(ACC_W'(wTap) + ACC_W'(delta));
    end

    // Control FSM plus all datapath state. in_ready is registered so that it
    // stays low while reset is asserted and rises on the first edge after
    // release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            tap_q       <= '0;
            ch_q        <= '0;
            d_q         <= '0;
            adapt_q     <= 1'b0;
            acc_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            ch_out_q    <= '0;
            y_q         <= '0;
            err_q       <= '0;
            for (int c = 0; c < N_CH; c++) begin
                for (int k = 0; k < FILTER_ORDER; k++) begin
                    xLine_q[c][k]  <= '0;
                    weight_q[c][k] <= '0;
                end
            end
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Out-of-range channels are silently dropped: stay idle
                    if (in_valid && in_ready_q && chValid) begin
                        for (int k = FILTER_ORDER - 1; k > 0; k--) begin
                            xLine_q[ch_in][k] <= xLine_q[ch_in][k-1];
                        end
                        xLine_q[ch_in][0] <= x_in;
                        d_q        <= d_in;
                        ch_q       <= ch_in;
                        adapt_q    <= adapt_en;
                        acc_q      <= '0;
                        tap_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_MAC;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_d;
                    if (tap_q == TAP_LAST) begin
                        tap_q   <= '0;
                        state_q <= S_ERR;
                    end else begin
                        tap_q <= tap_q + K_W'(1);
                    end
                end
                S_ERR: begin
                    y_q         <= y_d;
                    err_q       <= err_d;
                    ch_out_q    <= ch_q;
                    out_valid_q <= 1'b1;
                    if (adapt_q) begin
                        state_q <= S_UPDATE;
                    end else begin
                        state_q    <= S_IDLE;
                        in_ready_q <= 1'b1;
                    end
                end
                S_UPDATE: begin
                    weight_q[ch_q][tap_q] <= weight_d;
                    if (tap_q == TAP_LAST) begin
                        tap_q      <= '0;
                        state_q    <= S_IDLE;
                        in_ready_q <= 1'b1;
                    end else begin
                        tap_q <= tap_q + K_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign ch_out    = ch_out_q;
    assign y_out     = y_q;
    assign err_out   = err_q;

endmodule
